// File: rtl/lut_based_nco.sv
// Sine NCO: a phase accumulator addresses a full-cycle sine table built from a quarter wave,
// and the two fractional phase bits linearly interpolate between adjacent table entries.
module lut_based_nco #(
  parameter int LUT_WIDTH  = 16,
  parameter int LUT_LENGTH = 6
) (
  input  logic                        iclk,
  input  logic                        ireset,
  input  logic signed [LUT_LENGTH+2:0] istep,
  output logic signed [LUT_WIDTH-1:0]  odata
);

  localparam int PHASE_INT    = LUT_LENGTH;
  localparam int PHASE_FRAC   = 2;
  localparam int ACC_SIZE     = PHASE_INT + PHASE_FRAC;
  localparam int QUARTER_BITS = LUT_LENGTH - 2;

  // The stored quarter wave holds round-half-away-from-zero values for 16-bit / 64-entry only.
  if (LUT_WIDTH != 16 || LUT_LENGTH != 6) begin : gUnsupported
    $error("lut_based_nco: quarter-wave table is only provided for LUT_WIDTH=16, LUT_LENGTH=6");
  end

  function automatic logic signed [LUT_WIDTH-1:0] quarterSine(input logic [QUARTER_BITS:0] idx);
    logic signed [LUT_WIDTH-1:0] v;
    case (int'(idx))
      0:       v = LUT_WIDTH'(0);
      1:       v = LUT_WIDTH'(3212);
      2:       v = LUT_WIDTH'(6393);
      3:       v = LUT_WIDTH'(9512);
      4:       v = LUT_WIDTH'(12539);
      5:       v = LUT_WIDTH'(15446);
      6:       v = LUT_WIDTH'(18204);
      7:       v = LUT_WIDTH'(20787);
      8:       v = LUT_WIDTH'(23170);
      9:       v = LUT_WIDTH'(25329);
      10:      v = LUT_WIDTH'(27245);
      11:      v = LUT_WIDTH'(28898);
      12:      v = LUT_WIDTH'(30273);
      13:      v = LUT_WIDTH'(31356);
      14:      v = LUT_WIDTH'(32137);
      15:      v = LUT_WIDTH'(32609);
      16:      v = LUT_WIDTH'(32767);
      default: v = LUT_WIDTH'(0);
    endcase
    return v;
  endfunction

  // Odd quadrants mirror the quarter index; the second half-period negates it.
  function automatic logic signed [LUT_WIDTH-1:0] sineAt(input logic [PHASE_INT-1:0] k);
    logic [QUARTER_BITS-1:0]     low;
    logic [QUARTER_BITS:0]       idx;
    logic signed [LUT_WIDTH-1:0] mag;
    low = k[QUARTER_BITS-1:0];
    if (k[QUARTER_BITS]) idx = (QUARTER_BITS+1)'(1 << QUARTER_BITS) - {1'b0, low};
    else                 idx = {1'b0, low};
    mag = quarterSine(idx);
    return k[PHASE_INT-1] ? -mag : mag;
  endfunction

  logic [ACC_SIZE-1:0]           acc_q, acc_d;
  logic signed [LUT_WIDTH-1:0]   data_q, data_d;
  logic [PHASE_INT-1:0]          phaseInt;
  logic [PHASE_FRAC-1:0]         phaseFrac;
  logic signed [LUT_WIDTH-1:0]   sCur, sNext;
  logic signed [LUT_WIDTH:0]     diff;
  logic signed [LUT_WIDTH+2:0]   prod;

  // The interpolated result always lies between sCur and sNext, so truncating to LUT_WIDTH is exact.
  always_comb begin
    phaseInt  = acc_q[ACC_SIZE-1:PHASE_FRAC];
    phaseFrac = acc_q[PHASE_FRAC-1:0];
    sCur      = sineAt(phaseInt);
    sNext     = sineAt(phaseInt + PHASE_INT'(1));
    diff      = (LUT_WIDTH+1)'(sNext) - (LUT_WIDTH+1)'(sCur);
    prod      = (LUT_WIDTH+3)'(diff) * (LUT_WIDTH+3)'($signed({1'b0, phaseFrac}));
    data_d    = LUT_WIDTH'((LUT_WIDTH+3)'(sCur) + (prod >>> PHASE_FRAC));
    acc_d     = ACC_SIZE'({1'b0, acc_q} + istep);
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      acc_q  <= '0;
      data_q <= '0;
    end else begin
      acc_q  <= acc_d;
      data_q <= data_d;
    end
  end

  assign odata = data_q;

endmodule

// File: tb/tb_lut_based_nco.sv
// Scoreboard bench for lut_based_nco: a real-arithmetic sine model predicts every sample,
// the driver queues predictions and an independent monitor pops and compares each clock.
module tb_lut_based_nco;

  logic              iclk = 1'b0;
  logic              ireset = 1'b1;
  logic signed [8:0] istep = '0;
  logic signed [15:0] odata;

  int sineTab[64];
  int modelAcc = 0;
  int expQ[$];
  int checks = 0;
  int passes = 0;

  lut_based_nco #(.LUT_WIDTH(16), .LUT_LENGTH(6)) dut (
    .iclk  (iclk),
    .ireset(ireset),
    .istep (istep),
    .odata (odata)
  );

  always #5 iclk = ~iclk;

  function automatic int floorDiv4(input int x);
    if (x >= 0) return x / 4;
    return -((-x + 3) / 4);
  endfunction

  function automatic int modelSample(input int a);
    int p, f, n, d;
    p = a / 4;
    f = a % 4;
    n = (p + 1) % 64;
    d = sineTab[n] - sineTab[p];
    return sineTab[p] + floorDiv4(d * f);
  endfunction

  task automatic checkOutput(input int expected, input string name);
    int actual;
    actual = int'(odata);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (check #%0d)", name, actual, expected, checks);
  endtask

  // Drive one edge's inputs at the falling edge and queue what that rising edge must produce.
  task automatic applyStimulus(input logic signed [8:0] step, input bit rst,
                               input bit useLit, input int lit);
    int modelOut;
    @(negedge iclk);
    istep  = step;
    ireset = rst;
    if (rst) begin
      modelOut = 0;
      modelAcc = 0;
    end else begin
      modelOut = modelSample(modelAcc);
      modelAcc = (((modelAcc + int'(step)) % 256) + 256) % 256;
    end
    expQ.push_back(useLit ? lit : modelOut);
  endtask

  task automatic runSteps(input logic signed [8:0] step, input int n);
    for (int i = 0; i < n; i++) applyStimulus(step, 1'b0, 1'b0, 0);
  endtask

  always @(posedge iclk) begin
    #1;
    if (expQ.size() > 0) checkOutput(expQ.pop_front(), "odata");
  end

  initial begin
    real v;
    int  lit;
    int  negSeq[5];
    for (int k = 0; k < 64; k++) begin
      v = 32767.0 * $sin(2.0 * 3.141592653589793 * real'(k) / 64.0);
      sineTab[k] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    end

    // Reset, then unit step: literal ramp, peak at acc=64, then a full period and more.
    applyStimulus(9'sd0, 1'b1, 1'b1, 0);
    applyStimulus(9'sd1, 1'b0, 1'b1, 0);
    applyStimulus(9'sd1, 1'b0, 1'b1, 803);
    applyStimulus(9'sd1, 1'b0, 1'b1, 1606);
    applyStimulus(9'sd1, 1'b0, 1'b1, 2409);
    applyStimulus(9'sd1, 1'b0, 1'b1, 3212);
    runSteps(9'sd1, 59);
    applyStimulus(9'sd1, 1'b0, 1'b1, 32767);
    runSteps(9'sd1, 260);

    // Step of 4 walks the raw table entries.
    applyStimulus(9'sd0, 1'b1, 1'b1, 0);
    for (int i = 0; i < 70; i++) begin
      case (i)
        0, 32, 64: lit = 0;
        1:  lit = 3212;
        2:  lit = 6393;
        8:  lit = 23170;
        16: lit = 32767;
        48: lit = -32767;
        63: lit = -3212;
        default: lit = -99999;
      endcase
      applyStimulus(9'sd4, 1'b0, lit != -99999, lit);
    end

    // Zero step and -256 both freeze the phase.
    runSteps(9'sd3, 5);
    runSteps(9'sd0, 10);
    runSteps(-9'sd256, 10);

    // Reset then -1: phase runs backwards through the last table entry.
    negSeq = '{0, -803, -1606, -2409, -3212};
    applyStimulus(9'sd0, 1'b1, 1'b1, 0);
    for (int i = 0; i < 5; i++) applyStimulus(-9'sd1, 1'b0, 1'b1, negSeq[i]);
    runSteps(-9'sd1, 260);

    // Mid-run reset restarts from phase 0, ignoring istep on the reset edge.
    runSteps(9'sd7, 20);
    applyStimulus(9'sd7, 1'b1, 1'b1, 0);
    applyStimulus(9'sd7, 1'b0, 1'b1, 0);
    applyStimulus(9'sd7, 1'b0, 1'b1, 5597);
    runSteps(9'sd7, 30);

    // Random segments with occasional resets.
    for (int s = 0; s < 24; s++) begin
      logic signed [8:0] rs;
      rs = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 9) == 0) applyStimulus(rs, 1'b1, 1'b0, 0);
      runSteps(rs, $urandom_range(1, 250));
    end

    @(posedge iclk);
    #3;
    checks++;
    if (expQ.size() == 0) passes++;
    else $display("[TB] FAIL drain: got %0d queued, expected 0", expQ.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: got no completion, expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
